// File: rtl/ip_send.sv
// ip_send: IPv4 transmit framer.
//
// On an accepted tx_start the packet parameters are latched, the ten
// 16-bit header words are summed into a 20-bit accumulator, and the
// accumulator is folded twice to form the one's-complement checksum.
// The framer then streams a 20-byte option-less IPv4 header followed by
// payload_len bytes passed straight through from the upstream source.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   tx_start              request to send (honoured only while idle)
//   protocol, payload_len,
//   local_ip, dest_ip     packet parameters, latched with tx_start
//   payload_data          current upstream payload byte
//   payload_rd            upstream advances one byte this cycle
//   tx_data, tx_valid,
//   tx_ready              byte stream towards the MAC
//   busy                  framer is not idle
//   done                  one-cycle pulse after the last byte is accepted
//   error                 one-cycle pulse when tx_start is rejected
module ip_send #(
   parameter logic [7:0]  TTL         = 8'd64,
   parameter logic [10:0] MAX_PAYLOAD = 11'd1480
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        tx_start,
   input  logic [7:0]  protocol,
   input  logic [10:0] payload_len,
   input  logic [31:0] local_ip,
   input  logic [31:0] dest_ip,
   input  logic [7:0]  payload_data,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        payload_rd,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SUM     = 3'd1,
      ST_FOLD    = 3'd2,
      ST_HEADER  = 3'd3,
      ST_PAYLOAD = 3'd4
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;

   logic [7:0]  proto_r;
   logic [10:0] len_r;
   logic [31:0] src_r;
   logic [31:0] dst_r;
   logic [15:0] ident_r;
   logic [19:0] acc_r;
   logic [10:0] cnt_r;
   logic        done_r;
   logic        error_r;

   logic [15:0] total_len_s;
   logic [15:0] checksum_s;
   logic [15:0] word_s;
   logic [7:0]  hdr_byte_s;
   logic        start_ok_s;
   logic        start_bad_s;
   logic        finish_s;
   logic        cnt_inc_s;
   logic        cnt_clr_s;

   // One end-around-carry fold of the 20-bit accumulator.
   function automatic logic [19:0] ones_fold(input logic [19:0] acc);
      ones_fold = {4'd0, acc[15:0]} + {16'd0, acc[19:16]};
   endfunction

   assign total_len_s = {5'd0, len_r} + 16'd20;
   assign checksum_s  = ~acc_r[15:0];
   assign done        = done_r;
   assign error       = error_r;

   // Header word being summed, indexed by the word counter (checksum field = 0).
   always_comb begin
      word_s = 16'h0000;
      case (cnt_r[3:0])
         4'd0:    word_s = 16'h4500;
         4'd1:    word_s = total_len_s;
         4'd2:    word_s = ident_r;
         4'd3:    word_s = 16'h4000;
         4'd4:    word_s = {TTL, proto_r};
         4'd5:    word_s = 16'h0000;
         4'd6:    word_s = src_r[31:16];
         4'd7:    word_s = src_r[15:0];
         4'd8:    word_s = dst_r[31:16];
         4'd9:    word_s = dst_r[15:0];
         default: word_s = 16'h0000;
      endcase
   end

   // Header byte on the wire, indexed by the byte counter (big-endian).
   always_comb begin
      hdr_byte_s = 8'h00;
      case (cnt_r[4:0])
         5'd0:    hdr_byte_s = 8'h45;
         5'd1:    hdr_byte_s = 8'h00;
         5'd2:    hdr_byte_s = total_len_s[15:8];
         5'd3:    hdr_byte_s = total_len_s[7:0];
         5'd4:    hdr_byte_s = ident_r[15:8];
         5'd5:    hdr_byte_s = ident_r[7:0];
         5'd6:    hdr_byte_s = 8'h40;
         5'd7:    hdr_byte_s = 8'h00;
         5'd8:    hdr_byte_s = TTL;
         5'd9:    hdr_byte_s = proto_r;
         5'd10:   hdr_byte_s = checksum_s[15:8];
         5'd11:   hdr_byte_s = checksum_s[7:0];
         5'd12:   hdr_byte_s = src_r[31:24];
         5'd13:   hdr_byte_s = src_r[23:16];
         5'd14:   hdr_byte_s = src_r[15:8];
         5'd15:   hdr_byte_s = src_r[7:0];
         5'd16:   hdr_byte_s = dst_r[31:24];
         5'd17:   hdr_byte_s = dst_r[23:16];
         5'd18:   hdr_byte_s = dst_r[15:8];
         5'd19:   hdr_byte_s = dst_r[7:0];
         default: hdr_byte_s = 8'h00;
      endcase
   end

   // Next-state and output decode; counters advance only on accepted bytes.
   always_comb begin
      state_nxt_s = state_r;
      tx_valid    = 1'b0;
      tx_data     = 8'h00;
      payload_rd  = 1'b0;
      busy        = 1'b1;
      start_ok_s  = 1'b0;
      start_bad_s = 1'b0;
      finish_s    = 1'b0;
      cnt_inc_s   = 1'b0;
      cnt_clr_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            busy = 1'b0;
            if (tx_start) begin
               if (payload_len > MAX_PAYLOAD) begin
                  start_bad_s = 1'b1;
               end else begin
                  start_ok_s  = 1'b1;
                  cnt_clr_s   = 1'b1;
                  state_nxt_s = ST_SUM;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SUM: begin
            if (cnt_r[3:0] == 4'd9) begin
               cnt_clr_s   = 1'b1;
               state_nxt_s = ST_FOLD;
            end else begin
               cnt_inc_s = 1'b1;
            end
         end
         ST_FOLD: begin
            if (cnt_r[0]) begin
               cnt_clr_s   = 1'b1;
               state_nxt_s = ST_HEADER;
            end else begin
               cnt_inc_s = 1'b1;
            end
         end
         ST_HEADER: begin
            tx_valid = 1'b1;
            tx_data  = hdr_byte_s;
            if (tx_ready) begin
               if (cnt_r[4:0] == 5'd19) begin
                  cnt_clr_s = 1'b1;
                  if (len_r != 11'd0) begin
                     state_nxt_s = ST_PAYLOAD;
                  end else begin
                     finish_s    = 1'b1;
                     state_nxt_s = ST_IDLE;
                  end
               end else begin
                  cnt_inc_s = 1'b1;
               end
            end else begin
               cnt_inc_s = 1'b0;
            end
         end
         ST_PAYLOAD: begin
            tx_valid   = 1'b1;
            tx_data    = payload_data;
            payload_rd = tx_ready;
            if (tx_ready) begin
               if (cnt_r == len_r - 11'd1) begin
                  cnt_clr_s   = 1'b1;
                  finish_s    = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  cnt_inc_s = 1'b1;
               end
            end else begin
               cnt_inc_s = 1'b0;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Latched parameters, checksum accumulator, counters, ident and pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         proto_r <= 8'h00;
         len_r   <= 11'd0;
         src_r   <= 32'h0000_0000;
         dst_r   <= 32'h0000_0000;
         ident_r <= 16'h0000;
         acc_r   <= 20'h0_0000;
         cnt_r   <= 11'd0;
         done_r  <= 1'b0;
         error_r <= 1'b0;
      end else begin
         done_r  <= finish_s;
         error_r <= start_bad_s;
         if (start_ok_s) begin
            proto_r <= protocol;
            len_r   <= payload_len;
            src_r   <= local_ip;
            dst_r   <= dest_ip;
         end
         if (start_ok_s) begin
            acc_r <= 20'h0_0000;
         end else if (state_r == ST_SUM) begin
            acc_r <= acc_r + {4'd0, word_s};
         end else if (state_r == ST_FOLD) begin
            acc_r <= ones_fold(acc_r);
         end
         if (cnt_clr_s) begin
            cnt_r <= 11'd0;
         end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + 11'd1;
         end
         if (finish_s) begin
            ident_r <= ident_r + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_ip_send.sv
// Self-checking bench for ip_send: directed packet scenarios with random
// payload contents, random MAC back-pressure and scrambled inputs after
// tx_start, checked against a byte-level model of the IPv4 frame.
module tb_ip_send;

   logic        clock = 1'b0;
   logic        reset;
   logic        tx_start;
   logic [7:0]  protocol;
   logic [10:0] payload_len;
   logic [31:0] local_ip;
   logic [31:0] dest_ip;
   logic [7:0]  payload_data;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        payload_rd;
   logic        busy;
   logic        done;
   logic        error;

   int total = 0;
   int bad   = 0;

   // upstream payload source and wire monitor
   logic [7:0]  pay_mem [0:2047];
   logic [10:0] rd_ptr = 11'd0;
   logic [7:0]  got_mem [0:8191];
   int          got_n  = 0;
   int          rd_n   = 0;
   int          done_n = 0;
   int          err_n  = 0;

   // reference model state
   logic [7:0]  exp_q [$];
   logic [15:0] exp_ident;
   logic [10:0] exp_len;
   logic [10:0] pay_base;
   int          got_base, rd_base, err_base;

   ip_send dut (
      .clock        (clock),
      .reset        (reset),
      .tx_start     (tx_start),
      .protocol     (protocol),
      .payload_len  (payload_len),
      .local_ip     (local_ip),
      .dest_ip      (dest_ip),
      .payload_data (payload_data),
      .tx_ready     (tx_ready),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .payload_rd   (payload_rd),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   always #5 clock = ~clock;

   assign payload_data = pay_mem[rd_ptr];

   always @(posedge clock) begin
      if (tx_valid && tx_ready) begin
         got_mem[got_n % 8192] <= tx_data;
         got_n <= got_n + 1;
      end
      if (payload_rd) begin
         rd_ptr <= rd_ptr + 11'd1;
         rd_n   <= rd_n + 1;
      end
      if (done)  done_n <= done_n + 1;
      if (error) err_n  <= err_n + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] got_byte(input int i);
      return got_mem[(got_base + i) % 8192];
   endfunction

   // Expected frame: header from the field layout with an arithmetic
   // one's-complement checksum, then the upstream bytes in order.
   task automatic build_exp(input logic [7:0] p, input logic [10:0] len,
                            input logic [31:0] src, input logic [31:0] dst);
      int          s;
      logic [15:0] tl;
      logic [15:0] ck;
      tl = 16'(len) + 16'd20;
      s  = 32'h4500 + int'(tl) + int'(exp_ident) + 32'h4000 + (64 * 256) + int'(p)
         + int'(src[31:16]) + int'(src[15:0]) + int'(dst[31:16]) + int'(dst[15:0]);
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      ck = ~16'(s);
      exp_q = {8'h45, 8'h00, tl[15:8], tl[7:0], exp_ident[15:8], exp_ident[7:0],
               8'h40, 8'h00, 8'd64, p, ck[15:8], ck[7:0],
               src[31:24], src[23:16], src[15:8], src[7:0],
               dst[31:24], dst[23:16], dst[15:8], dst[7:0]};
      for (int i = 0; i < int'(len); i++) exp_q.push_back(pay_mem[11'(int'(pay_base) + i)]);
   endtask

   // Called #1 after a rising edge: presents a request and records the model.
   task automatic start_pkt(input logic [7:0] p, input logic [10:0] len,
                            input logic [31:0] src, input logic [31:0] dst);
      protocol    = p;
      payload_len = len;
      local_ip    = src;
      dest_ip     = dst;
      tx_start    = 1'b1;
      exp_len     = len;
      pay_base    = rd_ptr;
      got_base    = got_n;
      rd_base     = rd_n;
      err_base    = err_n;
      build_exp(p, len, src, dst);
   endtask

   // Runs the packet until done, then compares the captured stream.
   task automatic run_pkt(input string nm, input bit rnd_ready, input bit inject);
      int cyc;
      int lat;
      int n;
      lat = -1;
      @(posedge clock); #1;
      tx_start    = 1'b0;
      protocol    = 8'($urandom);
      payload_len = 11'($urandom);
      local_ip    = $urandom;
      dest_ip     = $urandom;
      cyc = 1;
      while (done !== 1'b1 && cyc < 8000) begin
         if (tx_valid === 1'b1 && lat < 0) lat = cyc;
         tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (inject && (cyc == 5 || cyc == 40)) begin
            tx_start    = 1'b1;
            payload_len = 11'd2000;
         end else begin
            tx_start = 1'b0;
         end
         @(posedge clock); #1;
         cyc++;
      end
      tx_start = 1'b0;
      tx_ready = 1'b1;
      check({nm, " done"}, 32'(done), 32'd1);
      check({nm, " latency"}, 32'(lat), 32'd13);
      n = got_n - got_base;
      check({nm, " bytes"}, 32'(n), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < n; i++)
         check($sformatf("%s byte%0d", nm, i), 32'(got_byte(i)), 32'(exp_q[i]));
      check({nm, " rd_count"}, 32'(rd_n - rd_base), 32'(exp_len));
      check({nm, " no_error"}, 32'(err_n - err_base), 32'd0);
      exp_ident = exp_ident + 16'd1;
   endtask

   initial begin
      int w;
      for (int i = 0; i < 2048; i++) pay_mem[i] = 8'($urandom);
      reset       = 1'b1;
      tx_start    = 1'b0;
      protocol    = 8'h00;
      payload_len = 11'd0;
      local_ip    = 32'h0;
      dest_ip     = 32'h0;
      tx_ready    = 1'b1;
      exp_ident   = 16'h0000;
      repeat (3) @(posedge clock);
      #1;
      check("rst tx_valid", 32'(tx_valid), 32'd0);
      check("rst tx_data", 32'(tx_data), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst error", 32'(error), 32'd0);
      check("rst payload_rd", 32'(payload_rd), 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      // reference UDP packet, MAC always ready
      start_pkt(8'h11, 11'd95, 32'hC0A80001, 32'hC0A800C7);
      run_pkt("udp1", 1'b0, 1'b0);
      check("udp1 ck_hi", 32'(got_byte(10)), 32'hB8);
      check("udp1 ck_lo", 32'(got_byte(11)), 32'h61);
      @(posedge clock); #1;
      check("udp1 done_width", 32'(done), 32'd0);
      check("udp1 idle", 32'(busy), 32'd0);

      // same packet again: ident 1, checksum one lower
      start_pkt(8'h11, 11'd95, 32'hC0A80001, 32'hC0A800C7);
      run_pkt("udp2", 1'b0, 1'b0);
      check("udp2 ident_lo", 32'(got_byte(5)), 32'h01);
      check("udp2 ck_hi", 32'(got_byte(10)), 32'hB8);
      check("udp2 ck_lo", 32'(got_byte(11)), 32'h60);
      @(posedge clock); #1;

      // random back-pressure
      start_pkt(8'h11, 11'd95, 32'hC0A80001, 32'hC0A800C7);
      run_pkt("udp_stall", 1'b1, 1'b0);
      @(posedge clock); #1;

      // empty ICMP payload
      start_pkt(8'h01, 11'd0, $urandom, $urandom);
      run_pkt("icmp0", 1'b1, 1'b0);
      check("icmp0 tl_hi", 32'(got_byte(2)), 32'h00);
      check("icmp0 tl_lo", 32'(got_byte(3)), 32'h14);
      @(posedge clock); #1;

      // oversize request rejected
      payload_len = 11'd1481;
      tx_start    = 1'b1;
      @(posedge clock); #1;
      tx_start = 1'b0;
      check("over error", 32'(error), 32'd1);
      check("over busy", 32'(busy), 32'd0);
      check("over tx_valid", 32'(tx_valid), 32'd0);
      @(posedge clock); #1;
      check("over error_width", 32'(error), 32'd0);
      check("over tx_valid2", 32'(tx_valid), 32'd0);

      // largest legal payload
      start_pkt(8'h11, 11'd1480, $urandom, $urandom);
      run_pkt("max", 1'b1, 1'b0);
      @(posedge clock); #1;

      // reset while header byte 7 is on the wire
      start_pkt(8'h11, 11'd95, 32'hC0A80001, 32'hC0A800C7);
      @(posedge clock); #1;
      tx_start = 1'b0;
      w = 0;
      while ((got_n - got_base) < 7 && w < 100) begin
         @(posedge clock); #1;
         w++;
      end
      check("mid wait", 32'(got_n - got_base), 32'd7);
      check("mid byte7", 32'(tx_data), 32'(exp_q[7]));
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("mid tx_valid", 32'(tx_valid), 32'd0);
      check("mid busy", 32'(busy), 32'd0);
      check("mid tx_data", 32'(tx_data), 32'd0);
      exp_ident = 16'h0000;
      @(posedge clock); #1;
      start_pkt(8'h11, 11'd95, 32'hC0A80001, 32'hC0A800C7);
      run_pkt("after_rst", 1'b0, 1'b0);
      check("after_rst ck_hi", 32'(got_byte(10)), 32'hB8);
      check("after_rst ck_lo", 32'(got_byte(11)), 32'h61);
      @(posedge clock); #1;

      // tx_start while busy ignored; tx_start in the done cycle accepted
      start_pkt(8'h11, 11'd95, $urandom, $urandom);
      run_pkt("busy_start", 1'b0, 1'b1);
      start_pkt(8'($urandom), 11'($urandom_range(0, 200)), $urandom, $urandom);
      run_pkt("b2b", 1'b1, 1'b0);
      @(posedge clock); #1;
      check("end idle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
